// File: rtl/turn_signal_pkg.sv
// turn_signal_pkg
// Shared types and constants for the turn-signal sequencer.
//   state_t      : sequencer state encoding (IDLE, L1..L3, R1..R3, HAZ)
//   LAMPS_*      : 6-bit lamp patterns ordered {lc, lb, la, ra, rb, rc}
//   lamp_pattern : maps a state onto its lamp pattern
package turn_signal_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        HAZ  = 3'd7
    } state_t;

    // Bit order {lc, lb, la, ra, rb, rc}: the inner lamps sit next to each
    // other in the middle, so the sweep grows outward on each side.
    localparam logic [5:0] LAMPS_IDLE = 6'b000_000;
    localparam logic [5:0] LAMPS_L1   = 6'b001_000;
    localparam logic [5:0] LAMPS_L2   = 6'b011_000;
    localparam logic [5:0] LAMPS_L3   = 6'b111_000;
    localparam logic [5:0] LAMPS_R1   = 6'b000_100;
    localparam logic [5:0] LAMPS_R2   = 6'b000_110;
    localparam logic [5:0] LAMPS_R3   = 6'b000_111;
    localparam logic [5:0] LAMPS_HAZ  = 6'b111_111;

    function automatic logic [5:0] lamp_pattern(input state_t s);
        logic [5:0] p;
        p = LAMPS_IDLE;
        case (s)
            L1:      p = LAMPS_L1;
            L2:      p = LAMPS_L2;
            L3:      p = LAMPS_L3;
            R1:      p = LAMPS_R1;
            R2:      p = LAMPS_R2;
            R3:      p = LAMPS_R3;
            HAZ:     p = LAMPS_HAZ;
            default: p = LAMPS_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/turn_signal_sequencer_tick_gen.sv
// tick_gen
// Free-running step counter producing a one-cycle strobe every TICK_DIV cycles.
//   clk   : system clock
//   reset : synchronous active-high reset (counter back to 0)
//   tick  : high for the single cycle in which the count equals TICK_DIV-1
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/turn_signal_sequencer.sv
// turn_signal_sequencer
// Thunderbird-style tail-light controller driven by an internal step strobe.
//   clk           : system clock (only clock in the block)
//   reset         : synchronous active-high reset
//   left, right   : asynchronous turn requests, active-high
//   la, lb, lc    : left lamps, la innermost
//   ra, rb, rc    : right lamps, ra innermost
//   busy          : high whenever a sequence is running
//   tick          : one-cycle step strobe
module turn_signal_sequencer
    import turn_signal_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    output logic la,
    output logic lb,
    output logic lc,
    output logic ra,
    output logic rb,
    output logic rc,
    output logic busy,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_l_reg;
    logic [SYNC_STAGES-1:0] sync_r_reg;
    logic                   left_s;
    logic                   right_s;
    logic                   pend_l_reg;
    logic                   pend_r_reg;
    logic                   launch;
    state_t                 state_reg;
    state_t                 state_next;
    logic [5:0]             lamps_reg;
    logic                   busy_reg;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Plain shift-register synchronizers; bit 0 is the metastability stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_l_reg <= '0;
            sync_r_reg <= '0;
        end else begin
            sync_l_reg <= {sync_l_reg[SYNC_STAGES-2:0], left};
            sync_r_reg <= {sync_r_reg[SYNC_STAGES-2:0], right};
        end
    end

    assign left_s  = sync_l_reg[SYNC_STAGES-1];
    assign right_s = sync_r_reg[SYNC_STAGES-1];

    // A sequence launches only from IDLE on a tick with something pending.
    assign launch = tick && (state_reg == IDLE) && (pend_l_reg || pend_r_reg);

    // Sticky request latches. The launch clear takes priority over a request
    // arriving in the same cycle, so that request is absorbed by the launch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_l_reg <= 1'b0;
            pend_r_reg <= 1'b0;
        end else if (launch) begin
            pend_l_reg <= 1'b0;
            pend_r_reg <= 1'b0;
        end else begin
            pend_l_reg <= pend_l_reg | left_s;
            pend_r_reg <= pend_r_reg | right_s;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pend_l_reg && pend_r_reg) state_next = HAZ;
                else if (pend_l_reg)          state_next = L1;
                else if (pend_r_reg)          state_next = R1;
                else                          state_next = IDLE;
            end
            L1:      state_next = L2;
            L2:      state_next = L3;
            L3:      state_next = IDLE;
            R1:      state_next = R2;
            R2:      state_next = R3;
            R3:      state_next = IDLE;
            HAZ:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lamps and busy are registered from the next state so they change on
    // the same edge as the state register and never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            lamps_reg <= LAMPS_IDLE;
            busy_reg  <= 1'b0;
        end else if (tick) begin
            state_reg <= state_next;
            lamps_reg <= lamp_pattern(state_next);
            busy_reg  <= (state_next != IDLE);
        end
    end

    assign {lc, lb, la, ra, rb, rc} = lamps_reg;
    assign busy = busy_reg;

endmodule
